// File: rtl/game_timer_ctl.sv
// rtl/game_timer_ctl.sv - GAME-state countdown timer with binary and BCD seconds remaining
// Optional pause input is built only when GAME_TIMER_PAUSE_EN is defined.
module game_timer_ctl #(
  parameter int CLK_HZ   = 40_000_000,
  parameter int GAME_SEC = 30
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
`ifdef GAME_TIMER_PAUSE_EN
  input  logic       pause,
`endif
  output logic       running,
  output logic       sec_tick,
  output logic       game_timer,
  output logic [6:0] sec_left,
  output logic [7:0] sec_bcd
);

  localparam int             PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]  PS_LAST  = PW'(CLK_HZ - 1);
  localparam logic [6:0]     SEC_INIT = 7'(GAME_SEC);
  localparam logic [7:0]     BCD_INIT = {4'(GAME_SEC / 10), 4'(GAME_SEC % 10)};

  if (GAME_SEC < 1 || GAME_SEC > 99) begin : g_bad_game_sec
    $error("game_timer_ctl: GAME_SEC must be in 1..99");
  end
  if (CLK_HZ < 2 || CLK_HZ > 67108864) begin : g_bad_clk_hz
    $error("game_timer_ctl: CLK_HZ must be in 2..2^26");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nx;
  logic [PW-1:0] prescaler, prescaler_nx;
  logic          running_nx, sec_tick_nx, game_timer_nx;
  logic [6:0]    sec_left_nx;
  logic [7:0]    sec_bcd_nx;
  logic [7:0]    bcd_dec;
  logic          hold, wrap, expire, do_start;

`ifdef GAME_TIMER_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  // abort outranks both a (re)start and a wrap on the same cycle
  assign do_start = start && !abort;
  assign wrap     = (state == RUN) && !abort && !start && !hold && (prescaler == PS_LAST);
  assign expire   = wrap && (sec_left == 7'd1);

  // BCD decrement tracks sec_left - 1 so both views always agree
  always_comb begin
    bcd_dec = sec_bcd;
    if (sec_bcd[3:0] == 4'd0)
      bcd_dec = {sec_bcd[7:4] - 4'd1, 4'd9};
    else
      bcd_dec = {sec_bcd[7:4], sec_bcd[3:0] - 4'd1};
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (do_start) state_nx = RUN;
      RUN: begin
        if (abort)
          state_nx = IDLE;
        else if (start)
          state_nx = RUN;
        else if (expire)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    prescaler_nx  = prescaler;
    running_nx    = running;
    sec_tick_nx   = 1'b0;
    game_timer_nx = 1'b0;
    sec_left_nx   = sec_left;
    sec_bcd_nx    = sec_bcd;
    case (state)
      IDLE: begin
        if (do_start) begin
          prescaler_nx = '0;
          running_nx   = 1'b1;
          sec_left_nx  = SEC_INIT;
          sec_bcd_nx   = BCD_INIT;
        end
      end
      RUN: begin
        if (abort) begin
          prescaler_nx = '0;
          running_nx   = 1'b0;
        end else if (start) begin
          prescaler_nx = '0;
          running_nx   = 1'b1;
          sec_left_nx  = SEC_INIT;
          sec_bcd_nx   = BCD_INIT;
        end else if (!hold) begin
          if (wrap) begin
            prescaler_nx = '0;
            sec_tick_nx  = 1'b1;
            sec_left_nx  = sec_left - 7'd1;
            sec_bcd_nx   = bcd_dec;
            if (expire) begin
              game_timer_nx = 1'b1;
              running_nx    = 1'b0;
            end
          end else begin
            prescaler_nx = prescaler + PW'(1);
          end
        end
      end
      default: running_nx = 1'b0;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      prescaler  <= '0;
      running    <= 1'b0;
      sec_tick   <= 1'b0;
      game_timer <= 1'b0;
      sec_left   <= SEC_INIT;
      sec_bcd    <= BCD_INIT;
    end else begin
      prescaler  <= prescaler_nx;
      running    <= running_nx;
      sec_tick   <= sec_tick_nx;
      game_timer <= game_timer_nx;
      sec_left   <= sec_left_nx;
      sec_bcd    <= sec_bcd_nx;
    end
  end

endmodule

// File: tb/tb_game_timer_ctl.sv
// tb/tb_game_timer_ctl.sv - directed-vector bench for game_timer_ctl
// Pause scenario is compiled only when GAME_TIMER_PAUSE_EN is defined.
module tb_game_timer_ctl;

  logic       pclk, rst, start, abort;
`ifdef GAME_TIMER_PAUSE_EN
  logic       pause;
`endif
  logic       run_a, tick_a, gt_a, run_b, tick_b, gt_b;
  logic [6:0] left_a, left_b;
  logic [7:0] bcd_a, bcd_b;
  int         vectors = 0;
  int         miscompares = 0;
  logic       seen;

  game_timer_ctl #(.CLK_HZ(10), .GAME_SEC(3)) dut_a (
    .pclk(pclk), .rst(rst), .start(start), .abort(abort),
`ifdef GAME_TIMER_PAUSE_EN
    .pause(pause),
`endif
    .running(run_a), .sec_tick(tick_a), .game_timer(gt_a),
    .sec_left(left_a), .sec_bcd(bcd_a)
  );

  game_timer_ctl #(.CLK_HZ(10), .GAME_SEC(12)) dut_b (
    .pclk(pclk), .rst(rst), .start(start), .abort(abort),
`ifdef GAME_TIMER_PAUSE_EN
    .pause(pause),
`endif
    .running(run_b), .sec_tick(tick_b), .game_timer(gt_b),
    .sec_left(left_b), .sec_bcd(bcd_b)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int v);
    return 32'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge pclk);
  endtask

  // set inputs for exactly one posedge, return at the following negedge
  task automatic drive(input logic s, input logic a);
    start = s;
    abort = a;
    @(negedge pclk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int ea, eb;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
`ifdef GAME_TIMER_PAUSE_EN
    pause = 1'b0;
`endif
    step(2);
    chk("rst_running", run_a, 0);
    chk("rst_sec_left", left_a, 3);
    chk("rst_sec_bcd", bcd_a, 8'h03);
    chk("rst_sec_tick", tick_a, 0);
    chk("rst_game_timer", gt_a, 0);
    chk("rst_sec_bcd_b", bcd_b, 8'h12);
    rst = 1'b0;
    step(2);

    // full countdown on both instances
    drive(1'b1, 1'b0);
    chk("t1_running_E", run_a, 1);
    chk("t1_sec_left_E", left_a, 3);
    for (int k = 1; k <= 120; k++) begin
      step(1);
      ea = (k >= 30) ? 0 : 3 - k / 10;
      chk("t1_sec_left", left_a, ea);
      chk("t1_sec_bcd", bcd_a, to_bcd(ea));
      chk("t1_sec_tick", tick_a, (k == 10 || k == 20 || k == 30) ? 1 : 0);
      chk("t1_game_timer", gt_a, (k == 30) ? 1 : 0);
      chk("t1_running", run_a, (k < 30) ? 1 : 0);
      eb = 12 - k / 10;
      chk("t2_sec_left", left_b, eb);
      chk("t2_sec_bcd", bcd_b, to_bcd(eb));
      chk("t2_sec_tick", tick_b, (k % 10 == 0) ? 1 : 0);
      chk("t2_game_timer", gt_b, (k == 120) ? 1 : 0);
    end

    // abort at E+15
    step(3);
    drive(1'b1, 1'b0);
    step(14);
    drive(1'b0, 1'b1);
    chk("t3_running", run_a, 0);
    chk("t3_sec_left", left_a, 2);
    chk("t3_sec_bcd", bcd_a, 8'h02);
    chk("t3_sec_tick", tick_a, 0);
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step(1);
      seen = seen | gt_a | tick_a;
    end
    chk("t3_no_pulse", seen, 0);
    chk("t3_sec_left_hold", left_a, 2);

    // start and abort together in RUN
    drive(1'b1, 1'b0);
    step(4);
    drive(1'b1, 1'b1);
    chk("t4_running", run_a, 0);
    chk("t4_sec_left", left_a, 3);
    step(1);
    chk("t4_stays_idle", run_a, 0);

    // restart at E+25
    step(2);
    drive(1'b1, 1'b0);
    step(24);
    chk("t5_sec_left_pre", left_a, 1);
    drive(1'b1, 1'b0);
    chk("t5_sec_left_reload", left_a, 3);
    chk("t5_running", run_a, 1);
    for (int k = 26; k <= 55; k++) begin
      step(1);
      chk("t5_game_timer", gt_a, (k == 55) ? 1 : 0);
      chk("t5_running_k", run_a, (k < 55) ? 1 : 0);
    end
    chk("t5_sec_left_end", left_a, 0);

    // asynchronous reset between edges at E+12
    step(2);
    drive(1'b1, 1'b0);
    step(12);
    chk("t6_sec_left_pre", left_a, 2);
    #2 rst = 1'b1;
    #1;
    chk("t6_running", run_a, 0);
    chk("t6_sec_left", left_a, 3);
    chk("t6_sec_bcd", bcd_a, 8'h03);
    chk("t6_sec_tick", tick_a, 0);
    chk("t6_game_timer", gt_a, 0);
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      seen = seen | gt_a | tick_a | run_a;
    end
    chk("t6_quiet", seen, 0);
    rst = 1'b0;
    step(1);
    chk("t6_sec_left_after", left_a, 3);

`ifdef GAME_TIMER_PAUSE_EN
    // pause over edges E+5..E+14 shifts expiry to E+40
    step(2);
    drive(1'b1, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      pause = (k >= 5 && k <= 14);
      step(1);
      chk("tp_running", run_a, (k < 40) ? 1 : 0);
      chk("tp_game_timer", gt_a, (k == 40) ? 1 : 0);
    end
    pause = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
